inv_key_schedule: RTL
=====================

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL have no parameters; it SHALL support AES-128 only (Nk=4, Nr=10), words and keys big-endian with bit 0 as MSB.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a schedule; sampled only in IDLE.
REQ-005 key_in  input  128  cipher key; captured on the edge that accepts start.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 rk_valid  output  1  rk_out/rk_round hold a valid round key.
REQ-008 rk_ready  input  1  consumer accepts the beat when rk_valid & rk_ready.
REQ-009 rk_out  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-010 rk_round  output  4  round index r of rk_out, 10 down to 0.
REQ-011 done  output  1  single-cycle pulse after round 0 is accepted.

Function
REQ-012 FSM states SHALL be IDLE, EXPAND, STREAM, FINISH; reset state IDLE.
REQ-013 IDLE: start=1 SHALL load key_in into the key register, clear round counter to 0, go to EXPAND; start=0 stays IDLE.
REQ-014 EXPAND: each cycle SHALL advance the key register one round forward (a'=a^SubWord(RotWord(d))^Rcon(r+1), b'=b^a', c'=c^b', d'=d^c'), increment counter; after the 10th update go to STREAM with counter=10.
REQ-015 Rcon(r) for r=1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 in the top byte, lower 24 bits zero.
REQ-016 rk_valid SHALL first rise exactly 10 clocks after the edge that accepted start, presenting round 10.
REQ-017 STREAM: rk_valid=1; rk_out=key register; rk_round=counter.
REQ-018 While rk_valid & !rk_ready, rk_out and rk_round SHALL hold stable.
REQ-019 On accept with counter>0, the next cycle SHALL present round counter-1 with no bubble, computed as d'=d^c, c'=c^b, b'=b^a, a'=a^SubWord(RotWord(d'))^Rcon(counter).
REQ-020 On accept with counter=0, the FSM SHALL go to FINISH; rk_valid SHALL drop the next cycle.
REQ-021 FINISH: done=1 for exactly one cycle, busy=0, then IDLE; a start in FINISH SHALL be ignored.
REQ-022 start asserted while busy SHALL be ignored and SHALL not disturb the schedule or key_in capture.
REQ-023 A single shared SubWord (4 S-boxes, FIPS-197 table) SHALL serve both forward and inverse steps.
REQ-024 Exactly 11 beats SHALL be emitted per start, rounds 10,9,...,0 in order; round 0 SHALL equal the captured key_in.

Reset
REQ-025 rst_n=0 SHALL force IDLE, busy=0, rk_valid=0, done=0, rk_out=0, rk_round=0, counter=0, at any state including mid-EXPAND or mid-STREAM.
REQ-026 After reset release the block SHALL accept start on the first rising edge with rst_n=1.

Verification
REQ-027 key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> beats r10=d014f9a8c9ee2589e13f0cc8b6630ca6, ..., r1=a0fafe1788542cb123a339392a6c7605, r0=key_in; done 1 cycle after r0.
REQ-028 key_in=000102030405060708090a0b0c0d0e0f -> first beat r10=13111d7fe3944a17f307a78b4d2b30c5 exactly 10 clocks after start edge.
REQ-029 Random rk_ready toggling (incl. low for 5 cycles on r10 and r0) -> outputs stable while stalled, sequence identical to REQ-027, no duplicated or skipped rounds.
REQ-030 start pulsed during EXPAND and STREAM with a different key_in -> ignored; output sequence matches first key.
REQ-031 rst_n low for one cycle during EXPAND (counter=5) and during STREAM (r=6) -> all outputs zero next cycle; new start then yields full correct 11-beat sequence.
REQ-032 Back-to-back: start asserted in the cycle following done -> accepted; second schedule correct.

Source files
------------

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule.
// Expands the cipher key forward to round 10, then streams the round keys
// in reverse order (10 down to 0) over a valid/ready handshake. The key
// register is stepped backwards one round per accepted beat, so only one
// round key is stored at any time. A single SubWord unit is used by both
// the forward and the inverse steps.
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t       state_r;
  logic [127:0] key_r;
  logic [3:0]   cnt_r;
  logic         busy_r;
  logic         valid_r;
  logic         done_r;

  logic [31:0]  a_s, b_s, c_s, d_s;
  logic [31:0]  d_prev_s;
  logic [31:0]  sub_in_s;
  logic [31:0]  sub_out_s;
  logic [3:0]   rcon_idx_s;
  logic [31:0]  rcon_word_s;
  logic [31:0]  fa_s, fb_s, fc_s, fd_s;
  logic [31:0]  ia_s;
  logic [127:0] fwd_key_s;
  logic [127:0] inv_key_s;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] a;
    logic [7:0] b;
    p = 8'h00;
    a = x;
    b = y;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (a & {8{b[0]}});
      a = {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // AES S-box: field inverse followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Next-round (forward) and previous-round (inverse) keys from one shared SubWord
  always_comb begin
    a_s      = key_r[127:96];
    b_s      = key_r[95:64];
    c_s      = key_r[63:32];
    d_s      = key_r[31:0];
    // last word of the previous round is recoverable without any S-box
    d_prev_s = d_s ^ c_s;
    if (state_r == STREAM) begin
      sub_in_s   = d_prev_s;
      rcon_idx_s = cnt_r;
    end else begin
      sub_in_s   = d_s;
      rcon_idx_s = cnt_r + 4'd1;
    end
    sub_out_s   = sub_word(rot_word(sub_in_s));
    rcon_word_s = {rcon(rcon_idx_s), 24'h000000};

    fa_s      = a_s ^ sub_out_s ^ rcon_word_s;
    fb_s      = b_s ^ fa_s;
    fc_s      = c_s ^ fb_s;
    fd_s      = d_s ^ fc_s;
    fwd_key_s = {fa_s, fb_s, fc_s, fd_s};

    ia_s      = a_s ^ sub_out_s ^ rcon_word_s;
    inv_key_s = {ia_s, b_s ^ a_s, c_s ^ b_s, d_prev_s};
  end

  // Control FSM with key register, round counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      key_r   <= 128'd0;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            key_r   <= key_in;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= EXPAND;
          end
        end
        EXPAND: begin
          key_r <= fwd_key_s;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == 4'd9) begin
            // tenth forward step: round 10 is presented straight away
            valid_r <= 1'b1;
            state_r <= STREAM;
          end
        end
        STREAM: begin
          if (valid_r && rk_ready) begin
            if (cnt_r == 4'd0) begin
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= FINISH;
            end else begin
              key_r <= inv_key_s;
              cnt_r <= cnt_r - 4'd1;
            end
          end
        end
        FINISH: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          key_r   <= 128'd0;
          cnt_r   <= 4'd0;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign rk_valid = valid_r;
  assign rk_out   = key_r;
  assign rk_round = cnt_r;
  assign done     = done_r;

endmodule
